// File: rtl/gpio_pulse_driver.sv
// gpio_pulse_driver
// Counts rising edges on trig, queues them, and replays each queued event on
// pin_out as one pulse. The pulse has a fixed active width and a fixed
// inactive gap, both measured in ticks of an internal divider.
// Every output comes straight from a flop. pin_out and busy are registered
// from the next-state value, so they change on the same edge as the state.
module gpio_pulse_driver #(
  parameter int SRC_CLK     = 50_000_000,
  parameter int TICK_HZ     = 115200,
  parameter int ON_TICKS    = 8,
  parameter int OFF_TICKS   = 8,
  parameter int PEND_W      = 4,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic              src_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              trig,
  output logic              pin_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TICK_DIV = ((SRC_CLK / TICK_HZ) > 1) ? (SRC_CLK / TICK_HZ) : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]   PH_ZERO   = PH_W'(0);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic              PIN_ACT   = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                trig_d_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [PH_W-1:0]     phase_r;
  logic [PEND_W-1:0]   pending_r;
  logic                overflow_r;
  logic                pin_r;
  logic                busy_r;

  logic                ev_s;
  logic                tick_s;
  logic                can_start_s;
  logic                start_s;
  logic                pin_s;
  logic                busy_s;
  logic                ovf_s;

  assign ev_s        = trig & ~trig_d_r;
  assign tick_s      = (state_r != IDLE) && (tick_cnt_r == TICK_LAST);
  assign can_start_s = (pending_r != PEND_ZERO) && en;

  // State register
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: phases end only on a tick; en gates only new starts
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (can_start_s) begin
          state_s = ON;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (tick_s && (phase_r == ON_LAST)) begin
          state_s = OFF;
        end else begin
          state_s = ON;
        end
      end
      OFF: begin
        if (tick_s && (phase_r == OFF_LAST)) begin
          if (can_start_s) begin
            state_s = ON;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = OFF;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode: a pulse starts whenever the machine enters ON
  always_comb begin
    start_s = (state_s == ON) && (state_r != ON);
    pin_s   = (state_s == ON) ? PIN_ACT : ~PIN_ACT;
    busy_s  = (state_s != IDLE);
    ovf_s   = ev_s && !start_s && (pending_r == PEND_MAX);
  end

  // Trigger delay register used for rising-edge detection
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d_r <= 1'b0;
    end else begin
      trig_d_r <= trig;
    end
  end

  // Tick divider: runs while busy, restarts on every pulse start
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_ZERO;
    end else if (start_s) begin
      tick_cnt_r <= TICK_ZERO;
    end else if (state_r != IDLE) begin
      tick_cnt_r <= tick_s ? TICK_ZERO : (tick_cnt_r + TICK_ONE);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Phase counter: counts ticks within a phase, cleared on any state change
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= PH_ZERO;
    end else if (state_s != state_r) begin
      phase_r <= PH_ZERO;
    end else if (tick_s) begin
      phase_r <= phase_r + PH_ONE;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Pending queue: +1 per edge, -1 per start, saturating without wrap
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= PEND_ZERO;
    end else if (ev_s && !start_s) begin
      if (pending_r != PEND_MAX) begin
        pending_r <= pending_r + PEND_ONE;
      end else begin
        pending_r <= pending_r;
      end
    end else if (start_s && !ev_s) begin
      pending_r <= pending_r - PEND_ONE;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Registered outputs: the pin goes inactive asynchronously on reset
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_r      <= ~PIN_ACT;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      pin_r      <= pin_s;
      busy_r     <= busy_s;
      overflow_r <= ovf_s;
    end
  end

  assign pin_out  = pin_r;
  assign busy     = busy_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_gpio_pulse_driver.sv
// tb_gpio_pulse_driver
// Directed scenarios followed by a random stretch, all checked every cycle
// against a timeline model. The model tracks the number of cycles since the
// current pulse started, plus a queue count.
module tb_gpio_pulse_driver;

  localparam int DIV    = 4;
  localparam int ON_T   = 2;
  localparam int OFF_T  = 3;
  localparam int PW     = 2;
  localparam int ON_CYC = ON_T * DIV;
  localparam int PERIOD = (ON_T + OFF_T) * DIV;
  localparam int PMAX   = (1 << PW) - 1;

  logic          src_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          trig    = 1'b0;
  logic          pin_out;
  logic          busy;
  logic          overflow;
  logic [PW-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model: m_t = cycles since the current pulse started (-1 when idle)
  int   m_pend      = 0;
  int   m_t         = -1;
  logic m_trig_prev = 1'b0;
  logic m_ovf       = 1'b0;

  int   ovf_seen    = 0;
  int   pulses_seen = 0;
  int   peak_seen   = 0;
  logic pin_prev    = 1'b0;

  gpio_pulse_driver #(
    .SRC_CLK    (16),
    .TICK_HZ    (4),
    .ON_TICKS   (ON_T),
    .OFF_TICKS  (OFF_T),
    .PEND_W     (PW),
    .ACTIVE_HIGH(1)
  ) dut (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .en      (en),
    .trig    (trig),
    .pin_out (pin_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  // Free-running source clock
  always #5 src_clk = ~src_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic ev;
    logic st;
    ev = trig && !m_trig_prev;
    m_trig_prev = trig;
    st = 1'b0;
    if (m_t < 0) begin
      st = (m_pend > 0) && en;
    end else if (m_t == PERIOD - 1) begin
      st = (m_pend > 0) && en;
      if (!st) m_t = -1;
    end
    if (st) m_t = 0;
    else if (m_t >= 0) m_t++;
    m_ovf = 1'b0;
    if (ev && !st) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end else if (st && !ev) begin
      m_pend--;
    end
  endtask

  task automatic compare_all();
    check_val("pin_out", pin_out, (m_t >= 0) && (m_t < ON_CYC));
    check_val("busy", busy, m_t >= 0);
    check_val("pending", pending, m_pend);
    check_val("overflow", overflow, m_ovf);
    if (overflow === 1'b1) ovf_seen++;
    if (pin_out === 1'b1 && pin_prev === 1'b0) pulses_seen++;
    if (int'(pending) > peak_seen) peak_seen = int'(pending);
    pin_prev = pin_out;
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare on negedge
  task automatic step(input logic t, input logic e);
    trig = t;
    en   = e;
    @(posedge src_clk);
    model_edge();
    @(negedge src_clk);
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    trig  = 1'b0;
    #1;
    check_val("rst_pin", pin_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_overflow", overflow, 0);
    m_pend = 0; m_t = -1; m_trig_prev = 1'b0; m_ovf = 1'b0; pin_prev = 1'b0;
    @(negedge src_clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_t >= 0 || m_pend > 0) && n < 500) begin
      step(1'b0, 1'b1);
      n++;
    end
    check_val("drain_idle", busy, 0);
  endtask

  initial begin
    int p0;
    int o0;
    int n;
    repeat (3) @(negedge src_clk);
    check_val("init_pin", pin_out, 0);
    check_val("init_busy", busy, 0);
    check_val("init_pending", pending, 0);
    check_val("init_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge src_clk);

    // 1: single event, latency and width
    p0 = pulses_seen;
    step(1'b1, 1'b1);
    check_val("t1_pend_after_edge", pending, 1);
    check_val("t1_pin_before", pin_out, 0);
    step(1'b0, 1'b1);
    check_val("t1_pin_start", pin_out, 1);
    check_val("t1_busy_start", busy, 1);
    check_val("t1_pend_start", pending, 0);
    drain();
    check_val("t1_pulses", pulses_seen - p0, 1);

    // 2: three edges two cycles apart
    p0 = pulses_seen;
    peak_seen = 0;
    repeat (3) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    drain();
    check_val("t2_pulses", pulses_seen - p0, 3);
    check_val("t2_peak", peak_seen, 2);

    // 3: saturation while busy, then 5: edge coincident with start at full queue
    p0 = pulses_seen;
    o0 = ovf_seen;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (5) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    check_val("t3_pend_sat", pending, 3);
    check_val("t3_ovf_count", ovf_seen - o0, 2);
    n = 0;
    while (m_t != PERIOD - 1 && n < 100) begin
      step(1'b0, 1'b1);
      n++;
    end
    check_val("t5_reached_boundary", n < 100, 1);
    step(1'b1, 1'b1);
    check_val("t5_pend_hold", pending, 3);
    check_val("t5_no_overflow", overflow, 0);
    check_val("t5_pin_restart", pin_out, 1);
    drain();
    check_val("t3_pulses", pulses_seen - p0, 5);

    // 4: en low holds off pulses while the queue grows
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_val("t4_pend_held", pending, 2);
    check_val("t4_pin_idle", pin_out, 0);
    step(1'b0, 1'b1);
    check_val("t4_pin_go", pin_out, 1);
    check_val("t4_pend_dec", pending, 1);
    drain();

    // 6: reset in the middle of an active phase with a queue
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_val("t6_pend_before", pending, 2);
    check_val("t6_pin_before", pin_out, 1);
    do_reset();
    p0 = pulses_seen;
    repeat (30) step(1'b0, 1'b1);
    check_val("t6_no_pulse", pulses_seen - p0, 0);

    // Random traffic with occasional resets
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
